// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the burst-writer FSM state type.
package fb_pkg;

    localparam logic [29:0] FRAME_BUFFER_ADDRESS = 30'h3800_0000;
    localparam int unsigned FRAME_BUFFER_WIDTH  = 800;
    localparam int unsigned FRAME_BUFFER_HEIGHT = 480;
    localparam int unsigned FRAME_BUFFER_LENGTH = FRAME_BUFFER_WIDTH * FRAME_BUFFER_HEIGHT * 4;

    localparam int unsigned SDRAM_ADDR_W = 29;
    localparam int unsigned SDRAM_DATA_W = 64;
    localparam int unsigned BURST_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        BURST,
        DONE
    } wr_state_t;

endpackage

// File: rtl/fb_write_fifo.sv
// First-word-fall-through FIFO holding packed 64-bit pixel pairs for the burst writer.
module fb_write_fifo
    import fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [SDRAM_DATA_W-1:0]       data_in,
    output logic [SDRAM_DATA_W-1:0]       data_out,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [SDRAM_DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop frees the slot the push lands in, so push is allowed while full.
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_burst_writer.sv
// Avalon-MM burst write master: packs a pixel stream into 64-bit words and writes one frame to SDRAM.
module fb_burst_writer
    import fb_pkg::*;
#(
    parameter logic [29:0] ADDRESS      = FRAME_BUFFER_ADDRESS,
    parameter int unsigned LENGTH       = FRAME_BUFFER_LENGTH,
    parameter int unsigned BURST_LENGTH = 8,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    buffer_select,
    input  logic [31:0]             pixel_data,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    output logic                    busy,
    output logic                    done,
    output logic [SDRAM_ADDR_W-1:0] address,
    output logic [BURST_W-1:0]      burstcount,
    input  logic                    waitrequest,
    output logic [SDRAM_DATA_W-1:0] writedata,
    output logic [7:0]              byteenable,
    output logic                    write
);

    localparam int unsigned TOTAL_WORDS  = LENGTH / 8;
    localparam int unsigned TOTAL_PIXELS = 2 * TOTAL_WORDS;
    localparam logic [SDRAM_ADDR_W-1:0] BASE0 = SDRAM_ADDR_W'(32'(ADDRESS) >> 3);
    localparam logic [SDRAM_ADDR_W-1:0] BASE1 = SDRAM_ADDR_W'((32'(ADDRESS) + LENGTH) >> 3);

    wr_state_t                   state;
    logic [SDRAM_ADDR_W-1:0]     next_addr;
    logic [31:0]                 words_remaining;
    logic [31:0]                 pixels_accepted;
    logic [BURST_W-1:0]          beats_left;
    logic [BURST_W-1:0]          this_burst;
    logic [31:0]                 half_data;
    logic                        half_valid;

    logic                        accept;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic [SDRAM_DATA_W-1:0]     fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;

    assign pixel_ready = busy && !fifo_full && (pixels_accepted < 32'(TOTAL_PIXELS));
    assign accept      = pixel_valid && pixel_ready;
    assign fifo_push   = accept && half_valid;
    assign fifo_pop    = write && !waitrequest;
    assign byteenable  = '1;
    // Head of the FIFO is the current beat; it only advances on an accepted beat.
    assign writedata   = write ? fifo_head : '0;

    always_comb begin
        this_burst = BURST_W'(BURST_LENGTH);
        if (words_remaining < 32'(BURST_LENGTH)) begin
            this_burst = words_remaining[BURST_W-1:0];
        end
    end

    fb_write_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .data_in ({pixel_data, half_data}),
        .data_out(fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            next_addr       <= '0;
            words_remaining <= '0;
            pixels_accepted <= '0;
            beats_left      <= '0;
            half_data       <= '0;
            half_valid      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            write           <= 1'b0;
            address         <= '0;
            burstcount      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        next_addr       <= buffer_select ? BASE1 : BASE0;
                        words_remaining <= 32'(TOTAL_WORDS);
                        pixels_accepted <= '0;
                        half_valid      <= 1'b0;
                        busy            <= 1'b1;
                        state           <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (!fifo_empty && (32'(fifo_count) >= 32'(this_burst))) begin
                        address    <= next_addr;
                        burstcount <= this_burst;
                        beats_left <= this_burst;
                        write      <= 1'b1;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (!waitrequest) begin
                        if (beats_left == 8'd1) begin
                            write           <= 1'b0;
                            next_addr       <= next_addr + SDRAM_ADDR_W'(burstcount);
                            words_remaining <= words_remaining - 32'(burstcount);
                            if (words_remaining == 32'(burstcount)) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                state <= WAIT_DATA;
                            end
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                pixels_accepted <= pixels_accepted + 1'b1;
                half_valid      <= !half_valid;
                if (!half_valid) begin
                    half_data <= pixel_data;
                end
            end
        end
    end

endmodule
